// File: rtl/forth_loader.sv
// forth_loader: framed byte-stream boot loader that fills instruction RAM and releases the forth core.
module forth_loader #(
    parameter int iaddr_width = 10,
    parameter int instr_width = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [iaddr_width-1:0] imem_addr,
    output logic [instr_width-1:0] imem_wdata,
    output logic                   imem_write,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   error
);
    typedef enum logic [2:0] {SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, RUN, ERROR} state_t;
    localparam logic [16:0] depth = 17'd1 << iaddr_width;
    state_t               state;
    logic [15:0]          len;
    logic [iaddr_width:0] cnt;
    logic [7:0]           csum;
    logic [7:0]           lo;
    logic                 accept;
    logic [16:0]          n_full;
    logic [iaddr_width:0] cnt_inc;
    logic                 last;
    assign accept  = rx_valid && rx_ready;
    assign n_full  = {1'b0, rx_data, len[7:0]};
    assign cnt_inc = cnt + (iaddr_width + 1)'(1);
    assign last    = 17'(cnt_inc) == {1'b0, len};
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SYNC;
            rx_ready   <= 1'b0;
            imem_write <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            len        <= '0;
            cnt        <= '0;
            csum       <= '0;
            lo         <= '0;
        end else begin
            imem_write <= 1'b0;
            rx_ready   <= state != RUN;
            if (accept) begin
                case (state)
                    SYNC:   state <= (rx_data == 8'hA5) ? LEN_LO : SYNC;
                    LEN_LO: begin
                        len[7:0] <= rx_data;
                        state    <= LEN_HI;
                    end
                    LEN_HI: begin
                        len[15:8] <= rx_data;
                        cnt       <= '0;
                        csum      <= '0;
                        state     <= (n_full == 17'd0 || n_full > depth) ? ERROR : DATA_LO;
                        error     <= n_full == 17'd0 || n_full > depth;
                    end
                    DATA_LO: begin
                        lo    <= rx_data;
                        csum  <= csum + rx_data;
                        state <= DATA_HI;
                    end
                    DATA_HI: begin
                        csum       <= csum + rx_data;
                        imem_write <= 1'b1;
                        imem_addr  <= cnt[iaddr_width-1:0];
                        imem_wdata <= instr_width'({rx_data, lo});
                        cnt        <= cnt_inc;
                        state      <= last ? CSUM : DATA_LO;
                    end
                    CSUM: begin
                        // a matching checksum releases the core on this very edge
                        state     <= (rx_data == csum) ? RUN : ERROR;
                        error     <= rx_data != csum;
                        rx_ready  <= rx_data != csum;
                        cpu_reset <= rx_data != csum;
                        done      <= rx_data == csum;
                    end
                    ERROR: begin
                        state <= (rx_data == 8'hA5) ? LEN_LO : ERROR;
                        error <= rx_data != 8'hA5;
                    end
                    RUN: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_forth_loader.sv
// tb_forth_loader: randomized frame loads checked against a queue-based model of the loader.
module tb_forth_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [9:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        imem_write;
    logic        cpu_reset;
    logic        done;
    logic        error;
    int          n_vec = 0;
    int          n_err = 0;
    logic [25:0] got[$];
    logic [25:0] exp_q[$];
    logic [15:0] words[$];

    forth_loader dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_write(imem_write),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_write) got.push_back({imem_addr, imem_wdata});

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int t = 0;
        if (stall) repeat ($urandom_range(3, 0)) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] bad, input bit stall);
        logic [7:0]  s = 8'h00;
        logic [15:0] n = 16'(words.size());
        send_byte(8'hA5, stall);
        send_byte(n[7:0], stall);
        send_byte(n[15:8], stall);
        foreach (words[i]) begin
            send_byte(words[i][7:0], stall);
            send_byte(words[i][15:8], stall);
            s = s + words[i][7:0] + words[i][15:8];
            exp_q.push_back({10'(i), words[i]});
        end
        send_byte(s ^ bad, stall);
        rx_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_write_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk({tag, "_write"}, 32'(got[i]), 32'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    task automatic status(input string tag, input bit rdy, input bit cr, input bit dn, input bit er);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'(rdy));
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cr));
        chk({tag, "_done"}, 32'(done), 32'(dn));
        chk({tag, "_error"}, 32'(error), 32'(er));
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("rst_imem_write", 32'(imem_write), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", 32'(imem_wdata), 32'd0);
        status("rst", 1'b0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_release_rx_ready", 32'(rx_ready), 32'd1);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        do_reset();
        words = {16'h1234, 16'hE040};
        send_frame(8'h00, 1'b0);
        check_writes("nominal");
        status("nominal", 1'b0, 1'b0, 1'b1, 1'b0);

        do_reset();
        send_frame(8'h01, 1'b0);
        check_writes("badcsum");
        status("badcsum", 1'b1, 1'b1, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0);
        check_writes("resend");
        status("resend", 1'b0, 1'b0, 1'b1, 1'b0);

        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        rx_valid = 1'b0;
        status("len0", 1'b1, 1'b1, 1'b0, 1'b1);
        send_byte(8'hA5, 1'b0);
        chk("len_rehunt_error", 32'(error), 32'd0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        rx_valid = 1'b0;
        status("len1025", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("len_error_no_writes", 32'(got.size()), 32'd0);
        words.delete();
        repeat (1024) words.push_back(16'($urandom));
        send_frame(8'h00, 1'b0);
        check_writes("len1024");
        status("len1024", 1'b0, 1'b0, 1'b1, 1'b0);

        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h12, 1'b0);
        words = {16'hABCD};
        send_frame(8'h00, 1'b0);
        check_writes("synchunt");
        status("synchunt", 1'b0, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            logic [7:0] bad;
            do_reset();
            words.delete();
            if (k == 0) words = {16'h1234, 16'hE040};
            else repeat ($urandom_range(8, 1)) words.push_back(16'($urandom));
            bad = (k % 3 == 2) ? 8'($urandom_range(255, 1)) : 8'h00;
            send_frame(bad, 1'b1);
            check_writes("stall");
            status("stall", bad != 0, bad != 0, bad == 0, bad != 0);
        end

        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h56, 1'b0);
        chk("midreset_partial_writes", 32'(got.size()), 32'd1);
        do_reset();
        words = {16'($urandom), 16'($urandom), 16'($urandom)};
        send_frame(8'h00, 1'b0);
        check_writes("after_midreset");
        status("after_midreset", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
